// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the shared TX FIFO.
// The master side is the requesters plus the FIFO; the arbiter sits on the slave side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   last;
  logic [N_REQ-1:0]   enable;
  logic [N_REQ-1:0]   ack;
  logic               fifo_full;
  logic               fifo_push;
  logic [7:0]         fifo_wdata;
  logic [N_REQ-1:0]   grant;
  logic               abort;
  logic [15:0]        frame_cnt;

  modport master (
    output req, data, last, enable, fifo_full,
    input  ack, fifo_push, fifo_wdata, grant, abort, frame_cnt
  );

  modport slave (
    input  req, data, last, enable, fifo_full,
    output ack, fifo_push, fifo_wdata, grant, abort, frame_cnt
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter: locks one requester onto the shared UART TX FIFO for a whole frame,
// releasing on its last byte, on loss of enable, or after too long without a push.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The counter never has to hold more than TIMEOUT-2: that value plus a quiet cycle aborts.
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 2);
  localparam logic [PW-1:0]    IDX_MAX  = PW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [PW-1:0]    r_owner;
  logic [PW-1:0]    r_rr_ptr;
  logic [TW-1:0]    r_tmo;
  logic [15:0]      r_frame_cnt;

  logic [N_REQ-1:0] w_cand;
  logic             w_sel_found;
  logic [PW-1:0]    w_sel_idx;
  logic [PW:0]      w_sum;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_rr_nxt;
  logic             w_push;
  logic             w_abort;
  logic             w_release;
  logic             w_done;
  logic [7:0]       w_wdata;

  assign w_cand   = bus.req & bus.enable;
  assign w_rr_nxt = (r_owner == IDX_MAX) ? '0 : r_owner + PW'(1);

  // Round-robin pick: scanning offsets high to low lets the one nearest rr_ptr win.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum       = {1'b0, r_rr_ptr} + (PW+1)'(k);
      w_idx       = (w_sum >= (PW+1)'(N_REQ)) ? PW'(w_sum - (PW+1)'(N_REQ)) : w_sum[PW-1:0];
      w_sel_found = w_sel_found | w_cand[w_idx];
      w_sel_idx   = w_cand[w_idx] ? w_idx : w_sel_idx;
    end
  end

  // Next state and the same-cycle FIFO handshake; IDLE values are the defaults.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_abort     = 1'b0;
    w_release   = 1'b0;
    w_done      = 1'b0;
    w_wdata     = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_state_nxt = ST_LOCK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCK: begin
        w_wdata = bus.data[{r_owner, 3'b000} +: 8];
        w_push  = bus.req[r_owner] & bus.enable[r_owner] & ~bus.fifo_full;
        if (!bus.enable[r_owner]) begin
          w_abort   = 1'b1;
          w_release = 1'b1;
        end else if (w_push) begin
          w_release = bus.last[r_owner];
          w_done    = bus.last[r_owner];
        end else if (r_tmo == TMO_LAST) begin
          w_abort   = 1'b1;
          w_release = 1'b1;
        end else begin
          w_release = 1'b0;
        end
        w_state_nxt = w_release ? ST_IDLE : ST_LOCK;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, owner and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_sel_found) begin
        r_grant <= ONE_HOT0 << w_sel_idx;
        r_owner <= w_sel_idx;
      end else if (w_release) begin
        r_grant  <= '0;
        r_rr_ptr <= w_rr_nxt;
      end else begin
        r_grant <= r_grant;
      end
    end
  end

  // Quiet-cycle counter: only runs inside a locked frame, stalls included.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo <= '0;
    end else if ((r_state == ST_IDLE) || w_push || w_release) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  // Completed-frame counter; wraps through zero on its own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= 16'h0000;
    end else if (w_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

  assign bus.fifo_push  = w_push;
  assign bus.fifo_wdata = w_wdata;
  assign bus.ack        = r_grant & {N_REQ{w_push}};
  assign bus.abort      = w_abort;
  assign bus.grant      = r_grant;
  assign bus.frame_cnt  = r_frame_cnt;
endmodule
